// File: rtl/noise_voice_if.sv
// Sample delivery bus between the noise voice and the voice mixer.
//   out_valid   voice -> mixer  sample available
//   out_ready   mixer -> voice  mixer accepts the sample this cycle
//   sample_out  voice -> mixer  8-bit unsigned offset-binary sample (0x80 = silence)
//   overrun     voice -> mixer  1-cycle pulse whenever a sample or tick is lost
interface noise_voice_if;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] sample_out;
  logic       overrun;

  modport master (
    output out_valid,
    output sample_out,
    output overrun,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  sample_out,
    input  overrun,
    output out_ready
  );
endinterface

// File: rtl/noise_voice.sv
// Noise oscillator voice stage.
//
// A phase accumulator advances by freq on every audio sample tick. Each 0->1 transition of
// accumulator bit TAP pulses rnd_step to the upstream LFSR and latches its current word into a
// sample-and-hold register. The held word is optionally smoothed by a one-pole low-pass
// (coefficient 2^-SMOOTH_SHIFT) and one sample per tick is handed to the mixer over a
// valid/ready handshake.
//
// Ports:
//   clk          system clock
//   rst_n        synchronous active-low reset
//   sample_tick  1-cycle audio-rate strobe, ticks at least 4 clk apart
//   gate         1 = voice running, 0 = accumulator frozen and output gliding to 0x80
//   freq         phase increment added on each gated tick
//   rnd_in       LFSR output word
//   rnd_step     1-cycle advance enable to the LFSR
//   mix          sample bus to the mixer (out_valid/out_ready/sample_out/overrun)
//
// Pipeline for a tick accepted at cycle N:
//   N   StIdle: accumulate, detect rising TAP edge
//   N+1 StStep: pulse rnd_step and latch rnd_in if a step was detected
//   N+2 StFilt: update the low-pass
//   N+3 StOut : load the output register, raise out_valid
module noise_voice #(
  parameter int unsigned ACC_W        = 24,
  parameter int unsigned TAP          = 19,  // legal range 16..ACC_W-1
  parameter int unsigned SMOOTH_SHIFT = 0    // 0 bypasses the low-pass
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sample_tick,
  input  logic          gate,
  input  logic [15:0]   freq,
  input  logic [7:0]    rnd_in,
  output logic          rnd_step,
  noise_voice_if.master mix
);

  localparam int unsigned K  = SMOOTH_SHIFT;
  localparam int unsigned FW = 8 + K;

  // Filter state is kept with K fractional bits; silence is 0x80 in the integer part.
  localparam logic [FW-1:0] FiltRst = FW'(128) << K;

  typedef enum logic [1:0] {
    StIdle,
    StStep,
    StFilt,
    StOut
  } state_e;

  state_e          state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] acc_sum;
  logic             step_q, step_d;
  logic [7:0]       held_q, held_d;
  logic [FW-1:0]    filt_q, filt_d;
  logic [FW-1:0]    filt_next;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       sample_q, sample_d;
  logic             overrun_q, overrun_d;

  // Low-pass datapath
  logic [7:0]        target;
  logic [FW-1:0]     target_ext;
  logic signed [FW:0] diff;
  logic signed [FW:0] delta;

  assign acc_sum = acc_q + ACC_W'(freq);

  always_comb begin
    target     = gate ? held_q : 8'h80;
    target_ext = FW'(target) << K;
    // One extra bit so the difference keeps its sign before the arithmetic shift.
    diff       = $signed({1'b0, target_ext}) - $signed({1'b0, filt_q});
    delta      = diff >>> K;
    filt_next  = filt_q + delta[FW-1:0];
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    step_d      = step_q;
    held_d      = held_q;
    filt_d      = filt_q;
    out_valid_d = out_valid_q;
    sample_d    = sample_q;
    overrun_d   = 1'b0;
    rnd_step    = 1'b0;

    if (out_valid_q && mix.out_ready) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (sample_tick) begin
          // A muted voice keeps its phase, so it can never produce a step.
          if (gate) begin
            acc_d = acc_sum;
          end
          step_d  = gate & ~acc_q[TAP] & acc_sum[TAP];
          state_d = StStep;
        end
      end
      StStep: begin
        rnd_step = step_q;
        // The word is taken before the LFSR advances on this same edge.
        if (step_q) begin
          held_d = rnd_in;
        end
        state_d = StFilt;
      end
      StFilt: begin
        filt_d  = filt_next;
        state_d = StOut;
      end
      StOut: begin
        sample_d    = filt_q[K+7:K];
        out_valid_d = 1'b1;
        // An unaccepted sample is replaced; a simultaneous accept means nothing is lost.
        if (out_valid_q && !mix.out_ready) begin
          overrun_d = 1'b1;
        end
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Ticks landing mid-pipeline are dropped and flagged.
    if (sample_tick && (state_q != StIdle)) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      step_q      <= 1'b0;
      held_q      <= 8'h80;
      filt_q      <= FiltRst;
      out_valid_q <= 1'b0;
      sample_q    <= 8'h80;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      step_q      <= step_d;
      held_q      <= held_d;
      filt_q      <= filt_d;
      out_valid_q <= out_valid_d;
      sample_q    <= sample_d;
      overrun_q   <= overrun_d;
    end
  end

  assign mix.out_valid  = out_valid_q;
  assign mix.sample_out = sample_q;
  assign mix.overrun    = overrun_q;

endmodule
